cmd_arbiter: RTL and testbench

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter_if.sv | 38 +++
 rtl/cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cmd_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_arbiter_if.sv
// cmd_arbiter_if: command-request and command-issue signals of the arbiter.
//   Requests in : drv_req_i/drv_index_i/drv_arg_i, cmd12_req_i, cmd23_req_i/cmd23_arg_i
//   Control in  : abort_i (cancel everything), done_i (engine finished command)
//   Issue out   : start_o, index_o, arg_o, src_o
//   Status out  : busy_o, drv_pending_o, drv_overrun_o, timeout_o
// slave  = arbiter side, master = requester / command-engine side.
interface cmd_arbiter_if;
   logic        drv_req_i;
   logic [5:0]  drv_index_i;
   logic [31:0] drv_arg_i;
   logic        cmd12_req_i;
   logic        cmd23_req_i;
   logic [31:0] cmd23_arg_i;
   logic        abort_i;
   logic        done_i;
   logic        start_o;
   logic [5:0]  index_o;
   logic [31:0] arg_o;
   logic [1:0]  src_o;
   logic        busy_o;
   logic        drv_pending_o;
   logic        drv_overrun_o;
   logic        timeout_o;

   modport slave (
      input  drv_req_i, drv_index_i, drv_arg_i, cmd12_req_i, cmd23_req_i,
             cmd23_arg_i, abort_i, done_i,
      output start_o, index_o, arg_o, src_o, busy_o, drv_pending_o,
             drv_overrun_o, timeout_o
   );

   modport master (
      output drv_req_i, drv_index_i, drv_arg_i, cmd12_req_i, cmd23_req_i,
             cmd23_arg_i, abort_i, done_i,
      input  start_o, index_o, arg_o, src_o, busy_o, drv_pending_o,
             drv_overrun_o, timeout_o
   );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: arbitrates driver, auto-CMD23 and auto-CMD12 command requests
// onto a single command engine. Fixed priority CMD12 > CMD23 > driver, one
// command in flight, a watchdog on the engine's done_i and an enforced idle
// gap between commands.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : cmd_arbiter_if.slave (requests, abort/done, issue and status)
module cmd_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned GAP_CYCLES     = 8
) (
   input logic          clk_i,
   input logic          rst_ni,
   cmd_arbiter_if.slave bus
);

   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

   // pending/grant bit order: [2] CMD12, [1] CMD23, [0] driver
   state_t           r_state;
   logic [2:0]       r_pend;
   logic [5:0]       r_drv_idx;
   logic [31:0]      r_drv_arg;
   logic [31:0]      r_c23_arg;
   logic [TO_W-1:0]  r_to_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_start;
   logic [5:0]       r_index;
   logic [31:0]      r_arg;
   logic [1:0]       r_src;
   logic             r_busy;
   logic             r_overrun;
   logic             r_timeout;

   logic [2:0]       w_req;
   logic [2:0]       w_grant;
   logic [2:0]       w_pend_nxt;
   logic             w_overrun;

   assign w_req = {bus.cmd12_req_i, bus.cmd23_req_i, bus.drv_req_i};

   // Fixed-priority grant, only offered while idle.
   always_comb begin
      w_grant = 3'b000;
      if (r_state == S_IDLE) begin
         if (r_pend[2])      w_grant = 3'b100;
         else if (r_pend[1]) w_grant = 3'b010;
         else if (r_pend[0]) w_grant = 3'b001;
      end
   end

   // A request landing in its own grant cycle re-arms the flag.
   assign w_pend_nxt = (r_pend & ~w_grant) | w_req;
   // Driver slot is free again once its grant is taken this cycle.
   assign w_overrun  = bus.drv_req_i & r_pend[0] & ~w_grant[0];

   // Sequencer: pending flags, captures, state and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_pend    <= '0;
         r_drv_idx <= '0;
         r_drv_arg <= '0;
         r_c23_arg <= '0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
         r_start   <= 1'b0;
         r_index   <= '0;
         r_arg     <= '0;
         r_src     <= '0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else if (bus.abort_i) begin
         r_state   <= S_IDLE;
         r_pend    <= '0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_start   <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= w_overrun;
         r_pend    <= w_pend_nxt;
         if (bus.drv_req_i && !w_overrun) begin
            r_drv_idx <= bus.drv_index_i;
            r_drv_arg <= bus.drv_arg_i;
         end
         if (bus.cmd23_req_i) r_c23_arg <= bus.cmd23_arg_i;

         case (r_state)
            S_IDLE: begin
               if (|w_grant) begin
                  r_state <= S_START;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  if (w_grant[2]) begin
                     r_index <= 6'd12;
                     r_arg   <= '0;
                     r_src   <= 2'd2;
                  end else if (w_grant[1]) begin
                     r_index <= 6'd23;
                     r_arg   <= r_c23_arg;
                     r_src   <= 2'd1;
                  end else begin
                     r_index <= r_drv_idx;
                     r_arg   <= r_drv_arg;
                     r_src   <= 2'd0;
                  end
               end else begin
                  r_busy <= |w_pend_nxt;
               end
            end
            S_START: begin
               r_state  <= S_WAIT_DONE;
               r_to_cnt <= '0;
               r_busy   <= 1'b1;
            end
            S_WAIT_DONE: begin
               r_busy <= 1'b1;
               if (bus.done_i) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= '0;
               end else if (r_to_cnt == TO_LAST) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= '0;
                  r_timeout <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= |w_pend_nxt;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                  r_busy    <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.start_o       = r_start;
   assign bus.index_o       = r_index;
   assign bus.arg_o         = r_arg;
   assign bus.src_o         = r_src;
   assign bus.busy_o        = r_busy;
   assign bus.drv_pending_o = r_pend[0];
   assign bus.drv_overrun_o = r_overrun;
   assign bus.timeout_o     = r_timeout;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: a timestamp-based reference model predicts
// every start, timeout, overrun and per-cycle busy/pending value; a monitor
// compares them against the DUT.
module tb_cmd_arbiter;
   localparam int unsigned T = 24;
   localparam int unsigned G = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cmd_arbiter_if bus();

   cmd_arbiter #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {int cyc; logic [5:0] idx; logic [31:0] arg; logic [1:0] src;} start_t;
   typedef struct {int cyc; bit busy; bit dpend;} stat_t;

   start_t q_start[$];
   stat_t  q_stat[$];
   int     q_to[$];
   int     q_ovr[$];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int n_starts = 0;
   int n_to = 0;
   int n_ovr = 0;
   logic [5:0] last_idx = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // stimulus values applied on the next tick
   bit s_req, s_c12, s_c23, s_abort, s_done, s_rst;
   logic [5:0]  s_idx = '0;
   logic [31:0] s_arg = '0, s_a23 = '0;

   // reference model state: request flags, captures, and the timeline of the
   // command in flight (start cycle, last waiting cycle)
   bit [2:0]    m_pend;
   logic [5:0]  m_idx;
   logic [31:0] m_arg, m_a23;
   bit          m_act, m_done;
   int          m_start, m_wend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance the model by one cycle t whose inputs are the s_* values.
   task automatic model_step(input int t);
      bit [2:0] g;
      start_t   e;
      stat_t    s;
      g = 3'b000;
      if (s_rst || s_abort) begin
         m_pend = 3'b000;
         m_act  = 1'b0;
         if (s_rst) begin
            m_idx = '0; m_arg = '0; m_a23 = '0;
         end
         s.cyc = t + 1; s.busy = 1'b0; s.dpend = 1'b0;
         q_stat.push_back(s);
         return;
      end
      if (m_act && t > m_wend + int'(G)) m_act = 1'b0;
      if (!m_act && m_pend != 3'b000) begin
         e.cyc = t + 1;
         if (m_pend[2]) begin
            g = 3'b100; e.idx = 6'd12; e.arg = 32'd0; e.src = 2'd2;
         end else if (m_pend[1]) begin
            g = 3'b010; e.idx = 6'd23; e.arg = m_a23; e.src = 2'd1;
         end else begin
            g = 3'b001; e.idx = m_idx; e.arg = m_arg; e.src = 2'd0;
         end
         q_start.push_back(e);
         m_act = 1'b1; m_done = 1'b0;
         m_start = t + 1;
         m_wend  = t + 1 + int'(T);
      end else if (m_act && !m_done && t > m_start && t <= m_wend) begin
         if (s_done) begin
            m_wend = t; m_done = 1'b1;
         end else if (t == m_wend) begin
            q_to.push_back(t + 1);
         end
      end
      if (s_req && m_pend[0] && !g[0]) q_ovr.push_back(t + 1);
      else if (s_req) begin
         m_idx = s_idx; m_arg = s_arg;
      end
      if (s_c23) m_a23 = s_a23;
      m_pend = (m_pend & ~g) | {s_c12, s_c23, s_req};
      s.cyc   = t + 1;
      s.busy  = (m_act && (t + 1 <= m_wend + int'(G))) || (m_pend != 3'b000);
      s.dpend = m_pend[0];
      q_stat.push_back(s);
   endtask

   task automatic tick();
      bus.drv_req_i   = s_req;
      bus.drv_index_i = s_idx;
      bus.drv_arg_i   = s_arg;
      bus.cmd12_req_i = s_c12;
      bus.cmd23_req_i = s_c23;
      bus.cmd23_arg_i = s_a23;
      bus.abort_i     = s_abort;
      bus.done_i      = s_done;
      rst_n           = ~s_rst;
      model_step(cyc);
      @(posedge clk);
      @(negedge clk);
      s_req = 0; s_c12 = 0; s_c23 = 0; s_abort = 0; s_done = 0; s_rst = 0;
   endtask

   function automatic bit model_waiting();
      return m_act && !m_done && cyc > m_start && cyc <= m_wend;
   endfunction

   function automatic bit model_idle();
      return (m_pend == 3'b000) && (!m_act || cyc > m_wend + int'(G));
   endfunction

   // Run until the model is idle; dly >= 1 answers done_i dly cycles after start.
   task automatic run_idle(input int dly);
      for (int k = 0; k < 4 * int'(T + G) + 50 && !model_idle(); k++) begin
         if (dly > 0 && model_waiting() && cyc == m_start + dly) s_done = 1;
         tick();
      end
   endtask

   task automatic idle_ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Monitor: compares DUT outputs with the model's predictions.
   start_t ms;
   stat_t  mst;
   int     mi;
   always @(negedge clk) begin
      if (q_stat.size() > 0 && q_stat[0].cyc == cyc) begin
         mst = q_stat.pop_front();
         chk("busy_o", 64'(bus.busy_o), 64'(mst.busy));
         chk("drv_pending_o", 64'(bus.drv_pending_o), 64'(mst.dpend));
      end
      if (bus.start_o === 1'b1) begin
         n_starts++;
         last_idx = bus.index_o;
         if (q_start.size() == 0) chk("start_o_unexpected", 64'(bus.start_o), 64'd0);
         else begin
            ms = q_start.pop_front();
            chk("start_cycle", 64'(cyc), 64'(ms.cyc));
            chk("index_o", 64'(bus.index_o), 64'(ms.idx));
            chk("arg_o", 64'(bus.arg_o), 64'(ms.arg));
            chk("src_o", 64'(bus.src_o), 64'(ms.src));
         end
      end
      while (q_start.size() > 0 && q_start[0].cyc < cyc) begin
         ms = q_start.pop_front();
         n_tests++; n_fail++;
         $display("FAIL start_missing: no start_o at cycle %0d, required index %0d", ms.cyc, ms.idx);
      end
      if (bus.timeout_o === 1'b1) begin
         n_to++;
         if (q_to.size() == 0) chk("timeout_o_unexpected", 64'(bus.timeout_o), 64'd0);
         else begin
            mi = q_to.pop_front();
            chk("timeout_cycle", 64'(cyc), 64'(mi));
         end
      end
      while (q_to.size() > 0 && q_to[0] < cyc) begin
         mi = q_to.pop_front();
         n_tests++; n_fail++;
         $display("FAIL timeout_missing: no timeout_o at cycle %0d, required 1", mi);
      end
      if (bus.drv_overrun_o === 1'b1) begin
         n_ovr++;
         if (q_ovr.size() == 0) chk("overrun_unexpected", 64'(bus.drv_overrun_o), 64'd0);
         else begin
            mi = q_ovr.pop_front();
            chk("overrun_cycle", 64'(cyc), 64'(mi));
         end
      end
      while (q_ovr.size() > 0 && q_ovr[0] < cyc) begin
         mi = q_ovr.pop_front();
         n_tests++; n_fail++;
         $display("FAIL overrun_missing: no drv_overrun_o at cycle %0d, required 1", mi);
      end
   end

   int snap;
   initial begin
      s_rst = 1; tick();
      s_rst = 1; tick();
      chk("rst_start_o", 64'(bus.start_o), 64'd0);
      chk("rst_index_o", 64'(bus.index_o), 64'd0);
      chk("rst_arg_o", 64'(bus.arg_o), 64'd0);
      chk("rst_src_o", 64'(bus.src_o), 64'd0);
      chk("rst_timeout_o", 64'(bus.timeout_o), 64'd0);
      chk("rst_overrun_o", 64'(bus.drv_overrun_o), 64'd0);
      idle_ticks(2);

      // single driver command, start two cycles after the request
      s_req = 1; s_idx = 6'd17; s_arg = 32'hDEADBEEF; tick();
      tick();
      chk("drv_start_o", 64'(bus.start_o), 64'd1);
      chk("drv_index_o", 64'(bus.index_o), 64'd17);
      chk("drv_arg_o", 64'(bus.arg_o), 64'hDEADBEEF);
      chk("drv_src_o", 64'(bus.src_o), 64'd0);
      run_idle(3);

      // all three sources at once: CMD12, CMD23, driver in order
      s_req = 1; s_idx = 6'd40; s_arg = 32'h1234_5678;
      s_c23 = 1; s_a23 = 32'h0000_0042; s_c12 = 1; tick();
      snap = n_starts;
      run_idle(4);
      chk("three_starts", 64'(n_starts - snap), 64'd3);
      chk("three_last_idx", 64'(last_idx), 64'd40);

      // watchdog timeout
      snap = n_to;
      s_req = 1; s_idx = 6'd7; s_arg = 32'hA5A5_0001; tick();
      run_idle(0);
      tick();
      chk("timeout_count", 64'(n_to - snap), 64'd1);

      // driver overrun while pending behind a CMD12
      snap = n_ovr;
      s_c12 = 1; tick();
      s_req = 1; s_idx = 6'd9; s_arg = 32'h0000_0009; tick();
      s_req = 1; s_idx = 6'd5; s_arg = 32'h0000_0005; tick();
      run_idle(3);
      chk("overrun_count", 64'(n_ovr - snap), 64'd1);
      chk("overrun_issued_idx", 64'(last_idx), 64'd9);

      // abort during WAIT_DONE with a CMD12 pending
      snap = n_starts;
      s_c12 = 1; tick(); tick(); tick();
      s_c12 = 1; tick(); tick();
      s_abort = 1; tick();
      chk("abort_busy_o", 64'(bus.busy_o), 64'd0);
      chk("abort_start_o", 64'(bus.start_o), 64'd0);
      idle_ticks(int'(T + G) + 5);
      chk("abort_no_restart", 64'(n_starts - snap), 64'd1);

      // CMD12 re-requested in its own grant cycle issues twice
      snap = n_starts;
      s_c12 = 1; tick();
      s_c12 = 1; tick();
      run_idle(2);
      chk("cmd12_twice", 64'(n_starts - snap), 64'd2);

      // reset in the middle of a command: nothing follows
      snap = n_starts + n_to;
      s_req = 1; s_idx = 6'd33; s_arg = 32'hCAFE_0033; tick();
      idle_ticks(4);
      s_rst = 1; tick();
      idle_ticks(int'(T + G) + 5);
      chk("rst_mid_quiet", 64'(n_starts + n_to - snap), 64'd1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         s_req = ($urandom_range(0, 5) == 0);
         s_idx = 6'($urandom_range(0, 63));
         s_arg = $urandom;
         s_c23 = ($urandom_range(0, 9) == 0);
         s_a23 = $urandom;
         s_c12 = ($urandom_range(0, 14) == 0);
         s_done = ($urandom_range(0, 9) == 0);
         s_abort = ($urandom_range(0, 299) == 0);
         s_rst = ($urandom_range(0, 999) == 0);
         tick();
      end

      run_idle(2);
      idle_ticks(3);
      chk("start_queue_drained", 64'(q_start.size()), 64'd0);
      chk("timeout_queue_drained", 64'(q_to.size()), 64'd0);
      chk("overrun_queue_drained", 64'(q_ovr.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
